// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, derived-total helpers and the RGB332 pixel type.
// Latency: n/a (package only).
// Backpressure: n/a.
// Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate:
// H_TOTAL=800, V_TOTAL=525, HS low on [656,751], VS low on [490,491].
package vga_timing_pkg;

   localparam int CNT_W = 10;   // wide enough for both 800 and 525

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // Width of one colour bar in the built-in test pattern.
   localparam int BAR_W = 80;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   function automatic int span_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int sync_first(input int active, input int fp);
      return active + fp;
   endfunction

   function automatic int sync_last(input int active, input int fp, input int sync);
      return active + fp + sync - 1;
   endfunction

   localparam int H_TOTAL      = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL      = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
   localparam int H_SYNC_START = sync_first(H_ACTIVE_DEF, H_FP_DEF);
   localparam int H_SYNC_END   = sync_last(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);
   localparam int V_SYNC_START = sync_first(V_ACTIVE_DEF, V_FP_DEF);
   localparam int V_SYNC_END   = sync_last(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-tick generator, h/v counters and registered HS/VS/display-enable decode.
// Latency: counters advance on each pix_tick; HS/VS/DE lag the counters by one tick.
// Backpressure: none, free-running raster.
// Ports: i_clk/i_rst_n clock and async active-low reset; o_pix_tick pixel strobe;
//        o_h_cnt/o_v_cnt counter registers; o_hs/o_vs/o_de registered sync and enable;
//        o_vis unregistered "current counters are visible", used by the colour mux.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic             o_pix_tick,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt,
   output logic             o_hs,
   output logic             o_vs,
   output logic             o_de,
   output logic             o_vis
);

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS    = CNT_W'(sync_first(H_ACTIVE, H_FP));
   localparam logic [CNT_W-1:0] H_SE    = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [CNT_W-1:0] V_SS    = CNT_W'(sync_first(V_ACTIVE, V_FP));
   localparam logic [CNT_W-1:0] V_SE    = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

   logic             r_phase;
   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;
   logic             r_hs;
   logic             r_vs;
   logic             r_de;

   logic w_tick;
   logic w_h_wrap;
   logic w_v_wrap;
   logic w_vis;
   logic w_hs_n;
   logic w_vs_n;

   // Phase is 0 out of reset, so the first tick lands on the second edge.
   assign w_tick   = r_phase;
   assign w_h_wrap = (r_h_cnt == H_LAST);
   assign w_v_wrap = (r_v_cnt == V_LAST);
   assign w_vis    = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
   assign w_hs_n   = !((r_h_cnt >= H_SS) && (r_h_cnt <= H_SE));
   assign w_vs_n   = !((r_v_cnt >= V_SS) && (r_v_cnt <= V_SE));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_tick) begin
         if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   // Decoded from the pre-increment counters, hence one tick behind posX/posY.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hs <= 1'b1;
         r_vs <= 1'b1;
         r_de <= 1'b0;
      end else if (w_tick) begin
         r_hs <= w_hs_n;
         r_vs <= w_vs_n;
         r_de <= w_vis;
      end
   end

   assign o_pix_tick = w_tick;
   assign o_h_cnt    = r_h_cnt;
   assign o_v_cnt    = r_v_cnt;
   assign o_hs       = r_hs;
   assign o_vs       = r_vs;
   assign o_de       = r_de;
   assign o_vis      = w_vis;

endmodule

// File: rtl/ctrl_circuit.sv
// VGA raster controller: sync generation plus registered RGB332 colour output.
// Latency: HS/VS/disp_en/RGB lag posX/posY by one pixel tick (two CLKIN_IN cycles).
// Backpressure: none; PIX_DATA is sampled on every pixel tick whether ready or not.
// Ports: CLKIN_IN 50 MHz clock; RST_IN async active-low reset; PIX_DATA RGB332 for
//        the current posX/posY; HS/VS active-low syncs; disp_en visible flag;
//        posX/posY counter values; Red/Green/Blue colour drive.
// Build option: define CTRL_CIRCUIT_TESTPAT_EN to replace PIX_DATA with eight
// 80-pixel vertical colour bars; sync and enable timing are identical either way.
module ctrl_circuit
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
)
(
   input  logic       CLKIN_IN,
   input  logic       RST_IN,
   input  logic [7:0] PIX_DATA,
   output logic       HS,
   output logic       VS,
   output logic       disp_en,
   output logic [9:0] posX,
   output logic [9:0] posY,
   output logic [2:0] Red,
   output logic [2:0] Green,
   output logic [1:0] Blue
);

   logic             w_tick;
   logic             w_vis;
   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   rgb332_t          w_pix;
   rgb332_t          w_rgb_nxt;
   rgb332_t          r_rgb;

   vga_sync_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_sync (
      .i_clk      (CLKIN_IN),
      .i_rst_n    (RST_IN),
      .o_pix_tick (w_tick),
      .o_h_cnt    (w_h_cnt),
      .o_v_cnt    (w_v_cnt),
      .o_hs       (HS),
      .o_vs       (VS),
      .o_de       (disp_en),
      .o_vis      (w_vis)
   );

`ifdef CTRL_CIRCUIT_TESTPAT_EN
   localparam logic [CNT_W-1:0] BAR_DIV = CNT_W'(BAR_W);
   logic [2:0] w_bar;

   // Each bar index bit drives a whole colour channel to full or zero.
   assign w_bar = 3'(w_h_cnt / BAR_DIV);
   assign w_pix = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
`else
   assign w_pix = PIX_DATA;
`endif

   assign w_rgb_nxt = w_vis ? w_pix : '0;

   always_ff @(posedge CLKIN_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         r_rgb <= '0;
      end else if (w_tick) begin
         r_rgb <= w_rgb_nxt;
      end
   end

   assign posX  = w_h_cnt;
   assign posY  = w_v_cnt;
   assign Red   = r_rgb.r;
   assign Green = r_rgb.g;
   assign Blue  = r_rgb.b;

endmodule

// File: tb/tb_ctrl_circuit.sv
// Bench for ctrl_circuit: one default-timing instance (line-level timing) and one
// shrunken-timing instance (whole frames), both checked against a cycle model.
// Expected outputs are queued when PIX_DATA is driven and popped on the next pixel tick.
`timescale 1ns/1ps
module tb_ctrl_circuit;

   localparam int S_HA = 16, S_HF = 4, S_HS = 8, S_HB = 4;
   localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;

   localparam int HA  [2] = '{640, S_HA};
   localparam int HF  [2] = '{16,  S_HF};
   localparam int HSW [2] = '{96,  S_HS};
   localparam int HT  [2] = '{800, S_HA + S_HF + S_HS + S_HB};
   localparam int VA  [2] = '{480, S_VA};
   localparam int VF  [2] = '{10,  S_VF};
   localparam int VSW [2] = '{2,   S_VS};
   localparam int VT  [2] = '{525, S_VA + S_VF + S_VS + S_VB};

   // {HS, VS, disp_en, Red, Green, Blue}
   localparam logic [10:0] RST_OUT = 11'h600;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pix;

   always #10 clk = ~clk;

   logic       hs0, vs0, de0, hs1, vs1, de1;
   logic [9:0] x0, y0, x1, y1;
   logic [2:0] r0, g0, r1, g1;
   logic [1:0] b0, b1;

   ctrl_circuit u_dut0 (
      .CLKIN_IN (clk), .RST_IN (rst_n), .PIX_DATA (pix),
      .HS (hs0), .VS (vs0), .disp_en (de0), .posX (x0), .posY (y0),
      .Red (r0), .Green (g0), .Blue (b0)
   );

   ctrl_circuit #(
      .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
   ) u_dut1 (
      .CLKIN_IN (clk), .RST_IN (rst_n), .PIX_DATA (pix),
      .HS (hs1), .VS (vs1), .disp_en (de1), .posX (x1), .posY (y1),
      .Red (r1), .Green (g1), .Blue (b1)
   );

   logic [10:0] dut_out [2];
   logic [9:0]  dut_x   [2];
   logic [9:0]  dut_y   [2];

   always_comb begin
      dut_out[0] = {hs0, vs0, de0, r0, g0, b0};
      dut_out[1] = {hs1, vs1, de1, r1, g1, b1};
      dut_x[0]   = x0;
      dut_x[1]   = x1;
      dut_y[0]   = y0;
      dut_y[1]   = y1;
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_h [2];
   int          m_v [2];
   bit          m_phase;
   bit          meas_en;
   logic [10:0] cur      [2];
   logic [10:0] prev_out [2];
   logic [10:0] sb0 [$];
   logic [10:0] sb1 [$];
   longint      hs_fall [$];
   longint      hs_rise [$];
   longint      de_rise [$];
   longint      vs_fall [$];
   longint      vs_rise [$];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [10:0] exp_out(input int i, input int h, input int v,
                                          input logic [7:0] p);
      logic       hs, vs, de;
      logic [7:0] rgb;
      int         k;
      hs  = !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HSW[i]));
      vs  = !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VSW[i]));
      de  = (h < HA[i]) && (v < VA[i]);
      rgb = 8'h00;
      k   = h / 80;
`ifdef CTRL_CIRCUIT_TESTPAT_EN
      if (de) rgb = {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
`else
      if (de) rgb = p;
`endif
      return {hs, vs, de, rgb};
   endfunction

   task automatic model_reset();
      m_phase = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_h[i]      = 0;
         m_v[i]      = 0;
         cur[i]      = RST_OUT;
         prev_out[i] = RST_OUT;
      end
      sb0.delete();
      sb1.delete();
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk_eq($sformatf("%s_out%0d", tag, i), 32'(dut_out[i]), 32'(RST_OUT));
         chk_eq($sformatf("%s_posx%0d", tag, i), 32'(dut_x[i]), 32'd0);
         chk_eq($sformatf("%s_posy%0d", tag, i), 32'(dut_y[i]), 32'd0);
      end
   endtask

   task automatic step(input logic [7:0] next_pix);
      logic [10:0] e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (m_phase) begin
            chk_eq($sformatf("sb_depth%0d", i), (i == 0) ? sb0.size() : sb1.size(), 32'd1);
            e = cur[i];
            if (i == 0 && sb0.size() > 0) e = sb0.pop_front();
            if (i == 1 && sb1.size() > 0) e = sb1.pop_front();
            cur[i] = e;
            if (m_h[i] == HT[i] - 1) begin
               m_h[i] = 0;
               m_v[i] = (m_v[i] == VT[i] - 1) ? 0 : m_v[i] + 1;
            end else begin
               m_h[i] = m_h[i] + 1;
            end
         end
         chk_eq($sformatf("out%0d", i), 32'(dut_out[i]), 32'(cur[i]));
         chk_eq($sformatf("posx%0d", i), 32'(dut_x[i]), 32'(m_h[i]));
         chk_eq($sformatf("posy%0d", i), 32'(dut_y[i]), 32'(m_v[i]));
      end
      if (meas_en) begin
         if (prev_out[0][10] && !dut_out[0][10]) hs_fall.push_back($time);
         if (!prev_out[0][10] && dut_out[0][10]) hs_rise.push_back($time);
         if (!prev_out[0][8] && dut_out[0][8])   de_rise.push_back($time);
         if (prev_out[1][9] && !dut_out[1][9])   vs_fall.push_back($time);
         if (!prev_out[1][9] && dut_out[1][9])   vs_rise.push_back($time);
      end
      prev_out[0] = dut_out[0];
      prev_out[1] = dut_out[1];
      m_phase = ~m_phase;
      pix = next_pix;
      if (m_phase) begin
         sb0.push_back(exp_out(0, m_h[0], m_v[0], pix));
         sb1.push_back(exp_out(1, m_h[1], m_v[1], pix));
      end
   endtask

   function automatic logic [31:0] qdiff(input longint a, input longint b);
      return 32'(a - b);
   endfunction

   initial begin
      logic [7:0] rnd;
      rst_n   = 1'b1;
      pix     = 8'h00;
      meas_en = 1'b0;
      model_reset();
      #5;
      rst_n = 1'b0;

      // Long reset hold: every output pinned at its reset value.
      for (int k = 0; k < 20; k++) begin
         #100;
         check_reset("rst_hold");
      end

      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      meas_en = 1'b1;

      // Two lines of constant PIX_DATA=5, then a line of random pixels.
      for (int k = 0; k < 3200; k++) step(8'd5);
      for (int k = 0; k < 1600; k++) begin
         rnd = 8'($urandom_range(0, 255));
         step(rnd);
      end
      meas_en = 1'b0;

      chk_eq("hs_falls", hs_fall.size(), 32'd3);
      chk_eq("hs_rises", hs_rise.size(), 32'd3);
      chk_eq("de_rises", de_rise.size(), 32'd3);
      chk_eq("vs_falls", vs_fall.size(), 32'd4);
      chk_eq("vs_rises", vs_rise.size(), 32'd4);
      chk_eq("hs_period_ns",
             (hs_fall.size() >= 2) ? qdiff(hs_fall[1], hs_fall[0]) : 32'd0, 32'd32000);
      chk_eq("hs_low_ns",
             (hs_fall.size() >= 1 && hs_rise.size() >= 1) ? qdiff(hs_rise[0], hs_fall[0]) : 32'd0,
             32'd3840);
      chk_eq("hs_fall_after_line_start_ns",
             (hs_fall.size() >= 1 && de_rise.size() >= 1) ? qdiff(hs_fall[0], de_rise[0]) : 32'd0,
             32'd26240);
      chk_eq("vs_period_ns",
             (vs_fall.size() >= 2) ? qdiff(vs_fall[1], vs_fall[0]) : 32'd0, 32'd24320);
      chk_eq("vs_low_ns",
             (vs_fall.size() >= 1 && vs_rise.size() >= 1) ? qdiff(vs_rise[0], vs_fall[0]) : 32'd0,
             32'd2560);

      // Move to the middle of a line, then pulse reset for 300 ns.
      for (int k = 0; k < 500; k++) begin
         rnd = 8'($urandom_range(0, 255));
         step(rnd);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("rst_async");
      for (int k = 0; k < 14; k++) begin
         #20;
         check_reset("rst_pulse");
      end
      #19;
      rst_n = 1'b1;
      model_reset();

      // Raster restarts from (0,0) and keeps tracking the model.
      for (int k = 0; k < 2000; k++) begin
         rnd = 8'($urandom_range(0, 255));
         step(rnd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
